hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Parametrised load-use and multiply/divide interlock for the pipelined MIPS core. It sits beside the IF/ID register and decides each cycle whether the instruction in ID may issue to EX. It tracks in-flight loads in an internal scoreboard sized by the configured load latency, so it supports deeper memory stages than the single-bubble 5-stage case. It also interlocks on a multi-cycle multiply/divide unit and keeps a saturating stall-cycle counter.

## Interface
- REG_ADDR_W, 5: register specifier width.
- LOAD_LAT, 1: cycles a load result is unavailable to forwarding after the load leaves ID. Legal range 1..8; 1 reproduces the classic one-bubble stall.
- MD_CYCLES, 32: busy cycles of the multiply/divide unit after issue. Legal range 1..63.
- ZERO_REG_EXEMPT, 1: when 1, specifier 0 never causes a hazard.
- CNT_W, 32: width of the stall counter.
---
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_kill  in  1  branch/jump flush of the ID instruction this cycle.
- id_rs, id_rt  in  REG_ADDR_W  source specifiers of the ID instruction.
- id_uses_rs, id_uses_rt  in  1  the ID instruction actually reads that source.
- id_load  in  1  the ID instruction is a load (memRead); its destination is id_rt.
- id_is_muldiv  in  1  the ID instruction is mult/multu/div/divu.
- id_reads_hilo  in  1  the ID instruction is mfhi/mflo.
- stall  out  1  hold IF and ID this cycle.
- pc_write  out  1  equals ~stall.
- ifid_write  out  1  equals ~stall.
- idex_bubble  out  1  load a NOP into ID/EX this cycle; equals stall | (id_valid & id_kill).
- stall_cause  out  2  00 none, 01 load-use, 10 mul/div, 11 both.
- md_busy  out  1  the multiply/divide unit is busy.
- stall_cycles  out  CNT_W  number of stalled cycles, saturating.

## Operation
- Scoreboard: LOAD_LAT entries {v, dest}. Entry 0 holds the youngest load, entry k holds a load k+1 cycles past ID.
  - Every cycle the entries shift toward the older end and the oldest entry is dropped.
  - Entry 0 is written with {1, id_rt} on an issued load, otherwise with {0, x}.
- issue = id_valid & ~id_kill & ~stall. A stalled or killed cycle pushes a bubble into entry 0.
- A load hazard exists when any entry is valid, dest matches a used source (rs with id_uses_rs, or rt with id_uses_rt), and dest is not 0 while ZERO_REG_EXEMPT is set.
- md_cnt is 6 bits:
  - On issue with id_is_muldiv, md_cnt is loaded with MD_CYCLES.
  - Otherwise, if md_cnt is nonzero, it decrements.
  - md_busy = (md_cnt != 0).
- A mul/div hazard exists when md_busy is high and (id_is_muldiv | id_reads_hilo).
- stall = id_valid & ~id_kill & (load_hz | md_hz). Kill has priority: a killed instruction never stalls.
- stall and stall_cause are combinational from the current state and the ID inputs, in the same cycle.
- stall_cycles increments on each cycle with stall=1 and holds at all-ones.
- While reset is high, stall is forced to 0.
- Reset, including mid-stall or mid-mul/div, does the following:
  - All scoreboard valid bits, md_cnt and stall_cycles are cleared on the next edge.
  - After release: stall=0, pc_write=1, ifid_write=1, idex_bubble=0 (given id_kill=0), stall_cause=00, md_busy=0, stall_cycles=0.

## Timing
- Issue decision latency is 0 cycles; state updates at the edge ending the cycle.
- A dependent instruction d instructions after a load (d=1 means adjacent) stalls max(0, LOAD_LAT−d+1) cycles.
- A load with no dependent costs 0 cycles. Back-to-back loads each occupy their own entry.
- Multiply/divide issued at edge t gives md_busy high for cycles t+1..t+MD_CYCLES. mfhi in ID at cycle t+MD_CYCLES+1 issues without stall.
- Simultaneous load-use and mul/div hazards raise stall_cause=11 and count as one stall cycle.
- A stall cycle still shifts the scoreboard, so load age advances while stalled. A stall never extends past the oldest matching entry.

## Test plan
- LOAD_LAT=1: issue lw $8, then add $9,$8,$3 → stall=1 for exactly 1 cycle, stall_cause=01, idex_bubble=1, stall_cycles=1, then the add issues.
- LOAD_LAT=2, lw $5 followed by an independent instruction, then sub using $5 → 1 stall cycle. With the dependent adjacent → 2 stall cycles.
- lw $0 followed by a reader of $0, with ZERO_REG_EXEMPT=1 → no stall. Same with ZERO_REG_EXEMPT=0 → 1 stall.
- MD_CYCLES=4: mult, then immediately mflo → stall for 4 cycles with stall_cause=10, md_busy falling after 4 cycles, then mflo issues. A second mult during busy also stalls.
- Load hazard present with id_kill=1 → stall=0, idex_bubble=1, scoreboard entry 0 invalid. Reset asserted mid-stall → next cycle stall=0, md_busy=0, stall_cycles=0.
- Force 2^CNT_W+3 stall cycles with CNT_W=4 → stall_cycles saturates at 15.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Decides every cycle whether the instruction held in IF/ID may issue to EX.
//   Two interlocks are tracked:
//     - load-use: a scoreboard of in-flight loads, LOAD_LAT entries deep,
//       entry k holding a load k+1 cycles past ID;
//     - mul/div : a 6-bit busy counter for the multi-cycle HI/LO unit.
//   A saturating counter records how many cycles were stalled.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   id_valid, id_kill           IF/ID holds a real instruction / it is flushed
//   id_rs, id_rt                source specifiers of the ID instruction
//   id_uses_rs, id_uses_rt      the ID instruction really reads that source
//   id_load                     ID instruction is a load writing id_rt
//   id_is_muldiv, id_reads_hilo mult/div family, mfhi/mflo
//   stall, pc_write, ifid_write hold request and its write-enable complements
//   idex_bubble                 insert a NOP into ID/EX
//   stall_cause                 {mul/div, load-use}
//   md_busy                     multiply/divide unit still busy
//   stall_cycles                saturating count of stalled cycles
module hazard_stall_unit #(
    parameter int unsigned REG_ADDR_W      = 5,
    parameter int unsigned LOAD_LAT        = 1,
    parameter int unsigned MD_CYCLES       = 32,
    parameter bit          ZERO_REG_EXEMPT = 1'b1,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic                  id_kill,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_load,
    input  logic                  id_is_muldiv,
    input  logic                  id_reads_hilo,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic [1:0]            stall_cause,
    output logic                  md_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dest;
    } sb_entry_t;

    sb_entry_t [LOAD_LAT-1:0] sb_q, sb_d;
    logic [5:0]               md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic load_hz;
    logic md_hz;
    logic live;
    logic issue;

    // An instruction that is absent, flushed, or seen during reset can
    // never be held.
    assign live = id_valid & ~id_kill & ~reset;

    always_comb begin
        load_hz = 1'b0;
        for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            if (sb_q[i].v && !(ZERO_REG_EXEMPT && sb_q[i].dest == '0)) begin
                if (id_uses_rs && sb_q[i].dest == id_rs) load_hz = 1'b1;
                if (id_uses_rt && sb_q[i].dest == id_rt) load_hz = 1'b1;
            end
        end
    end

    assign md_busy     = (md_cnt_q != '0);
    assign md_hz       = md_busy & (id_is_muldiv | id_reads_hilo);
    assign stall       = live & (load_hz | md_hz);
    assign stall_cause = live ? {md_hz, load_hz} : 2'b00;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign idex_bubble = stall | (id_valid & id_kill);
    assign issue       = id_valid & ~id_kill & ~stall;

    // Scoreboard shifts every cycle, stalled or not, so a held dependent
    // sees its producer age and the stall ends by itself.
    always_comb begin
        sb_d = sb_q;
        for (int unsigned i = 1; i < LOAD_LAT; i++) begin
            sb_d[i] = sb_q[i-1];
        end
        sb_d[0].v    = issue & id_load;
        sb_d[0].dest = id_rt;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (issue && id_is_muldiv) begin
            md_cnt_d = 6'(MD_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q     <= '0;
            md_cnt_q <= '0;
            cnt_q    <= '0;
        end else begin
            sb_q     <= sb_d;
            md_cnt_q <= md_cnt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit. Two instances share one input stream:
//   inst 0: LOAD_LAT=2, MD_CYCLES=4, ZERO_REG_EXEMPT=1, CNT_W=4
//   inst 1: LOAD_LAT=1, MD_CYCLES=6, ZERO_REG_EXEMPT=0, CNT_W=32
// The reference model remembers, per register, the cycle of the latest
// issued load, and the cycle of the latest issued mul/div.
module tb_hazard_stall_unit;

    localparam int LAT_A = 2, LAT_B = 1;
    localparam int MD_A  = 4, MD_B  = 6;
    localparam int ZRE_A = 1, ZRE_B = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_kill, id_uses_rs, id_uses_rt;
    logic       id_load, id_is_muldiv, id_reads_hilo;
    logic [4:0] id_rs, id_rt;

    logic       stall_w [2];
    logic       pcw_w   [2];
    logic       ifw_w   [2];
    logic       bub_w   [2];
    logic       busy_w  [2];
    logic [1:0] cause_w [2];
    logic [3:0]  cnt_a;
    logic [31:0] cnt_b;

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_LAT(LAT_A), .MD_CYCLES(MD_A),
                        .ZERO_REG_EXEMPT(1'b1), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_kill(id_kill),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_load(id_load), .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
        .stall(stall_w[0]), .pc_write(pcw_w[0]), .ifid_write(ifw_w[0]),
        .idex_bubble(bub_w[0]), .stall_cause(cause_w[0]), .md_busy(busy_w[0]),
        .stall_cycles(cnt_a));

    hazard_stall_unit #(.REG_ADDR_W(5), .LOAD_LAT(LAT_B), .MD_CYCLES(MD_B),
                        .ZERO_REG_EXEMPT(1'b0), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_kill(id_kill),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_load(id_load), .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
        .stall(stall_w[1]), .pc_write(pcw_w[1]), .ifid_write(ifw_w[1]),
        .idex_bubble(bub_w[1]), .stall_cause(cause_w[1]), .md_busy(busy_w[1]),
        .stall_cycles(cnt_b));

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    int         now = 0;
    int         ld_last [2][32];
    int         md_last [2];
    longint     m_cnt   [2];
    bit         e_stall [2];
    bit         e_bub   [2];
    bit         e_busy  [2];
    logic [1:0] e_cause [2];

    task automatic model_clear();
        for (int j = 0; j < 2; j++) begin
            for (int r = 0; r < 32; r++) ld_last[j][r] = -1000;
            md_last[j] = -1000;
            m_cnt[j]   = 0;
        end
    endtask

    task automatic model_eval();
        for (int j = 0; j < 2; j++) begin
            int lat = (j == 1) ? LAT_B : LAT_A;
            int mdc = (j == 1) ? MD_B  : MD_A;
            int zre = (j == 1) ? ZRE_B : ZRE_A;
            bit lhz, mhz, busy, lv;
            lhz = (id_uses_rs && (now - ld_last[j][id_rs]) <= lat && !(zre == 1 && id_rs == 5'd0))
               || (id_uses_rt && (now - ld_last[j][id_rt]) <= lat && !(zre == 1 && id_rt == 5'd0));
            busy = (now - md_last[j]) <= mdc;
            mhz  = busy && (id_is_muldiv || id_reads_hilo);
            lv   = id_valid && !id_kill && !reset;
            e_stall[j] = lv && (lhz || mhz);
            e_cause[j] = lv ? {mhz, lhz} : 2'b00;
            e_bub[j]   = e_stall[j] || (id_valid && id_kill);
            e_busy[j]  = busy;
        end
    endtask

    task automatic model_commit();
        if (reset) begin
            model_clear();
        end else begin
            for (int j = 0; j < 2; j++) begin
                longint cmax = (j == 1) ? 64'hFFFF_FFFF : 15;
                bit iss = id_valid && !id_kill && !e_stall[j];
                if (iss && id_load)      ld_last[j][id_rt] = now;
                if (iss && id_is_muldiv) md_last[j] = now;
                if (e_stall[j] && m_cnt[j] < cmax) m_cnt[j]++;
            end
        end
        now++;
    endtask

    function automatic logic [6:0] pack_obs(int j);
        logic lv = id_valid & ~id_kill & ~reset;
        return {stall_w[j], pcw_w[j], ifw_w[j], bub_w[j], busy_w[j], cause_w[j] & {2{lv}}};
    endfunction

    function automatic logic [6:0] pack_exp(int j);
        return {e_stall[j], ~e_stall[j], ~e_stall[j], e_bub[j], e_busy[j], e_cause[j]};
    endfunction

    function automatic logic [63:0] obs_cnt(int j);
        if (j == 1) return 64'(cnt_b);
        return 64'(cnt_a);
    endfunction

    // ---------------- stimulus plumbing ----------------
    typedef struct {
        bit v, k, ld, md, hl, urs, urt;
        bit [4:0] rs, rt;
        int ncyc;   // 0: hold until neither instance stalls, else exact cycles
        int ea, eb; // stall cycles required from inst 0 / inst 1
    } instr_t;

    function automatic instr_t mk(bit v, bit k, bit ld, bit md, bit hl, bit urs, bit urt,
                                  int rs, int rt, int ncyc, int ea, int eb);
        instr_t t;
        t.v = v; t.k = k; t.ld = ld; t.md = md; t.hl = hl; t.urs = urs; t.urt = urt;
        t.rs = 5'(rs); t.rt = 5'(rt); t.ncyc = ncyc; t.ea = ea; t.eb = eb;
        return t;
    endfunction

    task automatic apply(input instr_t t);
        id_valid = t.v; id_kill = t.k; id_load = t.ld; id_is_muldiv = t.md;
        id_reads_hilo = t.hl; id_uses_rs = t.urs; id_uses_rt = t.urt;
        id_rs = t.rs; id_rt = t.rt;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply(mk(0,0,0,0,0,0,0, 0,0, 1,0,0));
        do_reset(3);
        settle();
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (pack_obs(j) !== 7'b0110000) begin
                n_errors++;
                $display("FAIL reset_outputs inst%0d got %b want 0110000", j, pack_obs(j));
            end
            n_checks++;
            if (obs_cnt(j) !== 64'd0) begin
                n_errors++;
                $display("FAIL reset_count inst%0d got %0d want 0", j, obs_cnt(j));
            end
        end
        advance();
    endtask

    task automatic test_load_use();
        instr_t tbl[$];
        tbl.push_back(mk(1,0,1,0,0,1,0, 29,8, 0,0,0));  // lw $8
        tbl.push_back(mk(1,0,0,0,0,1,1,  8,3, 0,2,1));  // add $9,$8,$3
        tbl.push_back(mk(1,0,1,0,0,1,0, 29,5, 0,0,0));  // lw $5
        tbl.push_back(mk(1,0,0,0,0,1,1,  1,2, 0,0,0));  // independent
        tbl.push_back(mk(1,0,0,0,0,1,1,  5,4, 0,1,0));  // sub using $5
        tbl.push_back(mk(1,0,1,0,0,1,0, 29,0, 0,0,0));  // lw $0
        tbl.push_back(mk(1,0,0,0,0,1,1,  0,2, 0,0,1));  // reader of $0
        tbl.push_back(mk(1,0,1,0,0,1,0, 29,6, 0,0,0));  // lw $6
        tbl.push_back(mk(1,0,0,0,0,1,1,  2,6, 0,2,1));  // reads $6 through rt
        tbl.push_back(mk(1,0,1,0,0,1,0, 29,7, 0,0,0));  // lw $7
        tbl.push_back(mk(1,0,0,0,0,1,0,  1,7, 0,0,0));  // rt=$7 not read
        foreach (tbl[k]) begin
            int stl [2] = '{0, 0};
            bit done = 1'b0;
            apply(tbl[k]);
            for (int c = 0; c < 64 && !done; c++) begin
                settle();
                for (int j = 0; j < 2; j++) begin
                    n_checks++;
                    if (pack_obs(j) !== pack_exp(j)) begin
                        n_errors++;
                        $display("FAIL load_use step%0d inst%0d got %b want %b", k, j, pack_obs(j), pack_exp(j));
                    end
                    n_checks++;
                    if (obs_cnt(j) !== 64'(m_cnt[j])) begin
                        n_errors++;
                        $display("FAIL load_use_count step%0d inst%0d got %0d want %0d", k, j, obs_cnt(j), m_cnt[j]);
                    end
                    if (stall_w[j] === 1'b1) stl[j]++;
                end
                done = (tbl[k].ncyc == 0) ? !(e_stall[0] || e_stall[1]) : (c + 1 >= tbl[k].ncyc);
                advance();
            end
            n_checks++;
            if (!done) begin
                n_errors++;
                $display("FAIL load_use_timeout step%0d got stuck want issue", k);
            end
            n_checks++;
            if (stl[0] != tbl[k].ea || stl[1] != tbl[k].eb) begin
                n_errors++;
                $display("FAIL load_use_len step%0d got %0d/%0d want %0d/%0d", k, stl[0], stl[1], tbl[k].ea, tbl[k].eb);
            end
        end
    endtask

    task automatic test_kill();
        instr_t tbl[$];
        tbl.push_back(mk(1,0,1,0,0,1,0, 29,7,  0,0,0)); // lw $7
        tbl.push_back(mk(1,1,1,0,0,1,0,  7,12, 1,0,0)); // lw $12 reading $7, killed
        tbl.push_back(mk(1,0,0,0,0,1,1, 12,3,  0,0,0)); // reader of $12
        foreach (tbl[k]) begin
            int stl [2] = '{0, 0};
            bit done = 1'b0;
            apply(tbl[k]);
            for (int c = 0; c < 64 && !done; c++) begin
                settle();
                for (int j = 0; j < 2; j++) begin
                    n_checks++;
                    if (pack_obs(j) !== pack_exp(j)) begin
                        n_errors++;
                        $display("FAIL kill step%0d inst%0d got %b want %b", k, j, pack_obs(j), pack_exp(j));
                    end
                    n_checks++;
                    if (obs_cnt(j) !== 64'(m_cnt[j])) begin
                        n_errors++;
                        $display("FAIL kill_count step%0d inst%0d got %0d want %0d", k, j, obs_cnt(j), m_cnt[j]);
                    end
                    if (stall_w[j] === 1'b1) stl[j]++;
                end
                done = (tbl[k].ncyc == 0) ? !(e_stall[0] || e_stall[1]) : (c + 1 >= tbl[k].ncyc);
                advance();
            end
            n_checks++;
            if (!done || stl[0] != tbl[k].ea || stl[1] != tbl[k].eb) begin
                n_errors++;
                $display("FAIL kill_len step%0d got %0d/%0d want %0d/%0d", k, stl[0], stl[1], tbl[k].ea, tbl[k].eb);
            end
        end
    endtask

    task automatic test_muldiv();
        instr_t tbl[$];
        tbl.push_back(mk(1,0,0,1,0,1,1, 1,2, 0,0,0));   // mult
        tbl.push_back(mk(1,0,0,0,1,0,0, 0,0, 0,4,6));   // mflo right behind
        tbl.push_back(mk(1,0,0,1,0,1,1, 1,2, 0,0,0));   // mult
        tbl.push_back(mk(1,0,0,1,0,1,1, 3,4, 1,1,1));   // second mult while busy
        tbl.push_back(mk(0,0,0,0,0,0,0, 0,0, 8,0,0));   // idle until unit drains
        foreach (tbl[k]) begin
            int stl [2] = '{0, 0};
            bit done = 1'b0;
            apply(tbl[k]);
            for (int c = 0; c < 64 && !done; c++) begin
                settle();
                for (int j = 0; j < 2; j++) begin
                    n_checks++;
                    if (pack_obs(j) !== pack_exp(j)) begin
                        n_errors++;
                        $display("FAIL muldiv step%0d inst%0d got %b want %b", k, j, pack_obs(j), pack_exp(j));
                    end
                    n_checks++;
                    if (obs_cnt(j) !== 64'(m_cnt[j])) begin
                        n_errors++;
                        $display("FAIL muldiv_count step%0d inst%0d got %0d want %0d", k, j, obs_cnt(j), m_cnt[j]);
                    end
                    if (stall_w[j] === 1'b1) stl[j]++;
                end
                done = (tbl[k].ncyc == 0) ? !(e_stall[0] || e_stall[1]) : (c + 1 >= tbl[k].ncyc);
                advance();
            end
            n_checks++;
            if (!done || stl[0] != tbl[k].ea || stl[1] != tbl[k].eb) begin
                n_errors++;
                $display("FAIL muldiv_len step%0d got %0d/%0d want %0d/%0d", k, stl[0], stl[1], tbl[k].ea, tbl[k].eb);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        apply(mk(1,0,0,1,0,1,1, 1,2, 0,0,0));      // mult issues
        settle();
        advance();
        apply(mk(1,0,0,0,1,0,0, 0,0, 0,0,0));      // mflo, stalls
        for (int c = 0; c < 2; c++) begin
            settle();
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (stall_w[j] !== 1'b1 || cause_w[j] !== 2'b10) begin
                    n_errors++;
                    $display("FAIL mid_stall inst%0d got stall=%b cause=%b want 1/10", j, stall_w[j], cause_w[j]);
                end
            end
            advance();
        end
        reset = 1'b1;
        settle();
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (stall_w[j] !== 1'b0 || pcw_w[j] !== 1'b1) begin
                n_errors++;
                $display("FAIL in_reset inst%0d got stall=%b pc_write=%b want 0/1", j, stall_w[j], pcw_w[j]);
            end
        end
        advance();
        reset = 1'b0;
        settle();
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (pack_obs(j) !== 7'b0110000 || obs_cnt(j) !== 64'd0) begin
                n_errors++;
                $display("FAIL after_reset inst%0d got %b cnt=%0d want 0110000 cnt=0", j, pack_obs(j), obs_cnt(j));
            end
        end
        advance();
    endtask

    task automatic test_saturation();
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 2; s++) begin
                bit done = 1'b0;
                if (s == 0) apply(mk(1,0,0,1,0,1,1, 1,2, 0,0,0));
                else        apply(mk(1,0,0,0,1,0,0, 0,0, 0,0,0));
                for (int c = 0; c < 64 && !done; c++) begin
                    settle();
                    for (int j = 0; j < 2; j++) begin
                        n_checks++;
                        if (pack_obs(j) !== pack_exp(j) || obs_cnt(j) !== 64'(m_cnt[j])) begin
                            n_errors++;
                            $display("FAIL saturate r%0d inst%0d got %b/%0d want %b/%0d", r, j,
                                     pack_obs(j), obs_cnt(j), pack_exp(j), m_cnt[j]);
                        end
                    end
                    done = !(e_stall[0] || e_stall[1]);
                    advance();
                end
                n_checks++;
                if (!done) begin
                    n_errors++;
                    $display("FAIL saturate_timeout r%0d got stuck want issue", r);
                end
            end
        end
        settle();
        n_checks++;
        if (cnt_a !== 4'd15) begin
            n_errors++;
            $display("FAIL saturate_a got %0d want 15", cnt_a);
        end
        n_checks++;
        if (cnt_b !== 32'd36) begin
            n_errors++;
            $display("FAIL saturate_b got %0d want 36", cnt_b);
        end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 199) == 0);
            id_valid      = ($urandom_range(0, 9) < 8);
            id_kill       = ($urandom_range(0, 9) == 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_uses_rs    = ($urandom_range(0, 3) != 0);
            id_uses_rt    = ($urandom_range(0, 1) != 0);
            id_load       = ($urandom_range(0, 9) < 3);
            id_is_muldiv  = ($urandom_range(0, 24) == 0);
            id_reads_hilo = ($urandom_range(0, 9) == 0);
            settle();
            for (int j = 0; j < 2; j++) begin
                n_checks++;
                if (pack_obs(j) !== pack_exp(j)) begin
                    n_errors++;
                    $display("FAIL random cyc%0d inst%0d got %b want %b", c, j, pack_obs(j), pack_exp(j));
                end
                n_checks++;
                if (obs_cnt(j) !== 64'(m_cnt[j])) begin
                    n_errors++;
                    $display("FAIL random_count cyc%0d inst%0d got %0d want %0d", c, j, obs_cnt(j), m_cnt[j]);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        model_clear();
        reset = 1'b1;
        apply(mk(0,0,0,0,0,0,0, 0,0, 1,0,0));
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_kill();
        test_muldiv();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
